bringup_seq: RTL

Parametrised power-up sequencer for the top level. It releases up to N_STAGES sub-block resets (MAC, camera, DDR3, MJPEG, …) in a fixed order and waits for each sub-block's done flag. It hands the shared MDIO/SCCB pins to the stage being initialised and retries a stuck stage through its reset. On a fault it reports the failing stage instead of hanging. It replaces the hard-coded IDLE→MAC_INIT→CAM_INIT→INIT_DOWN chain in the top level.

---
 rtl/bringup_seq.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/bringup_seq.sv
// Power-up sequencer: releases sub-block resets in order, waits on each done flag,
// hands the shared bus to the active stage and retries a stuck stage through reset.
module bringup_seq #(
  parameter int unsigned         N_STAGES       = 4,
  parameter logic [N_STAGES-1:0] PARALLEL_MASK  = 4'b0001,
  parameter int unsigned         TIMEOUT_CYCLES = 2_700_000,
  parameter int unsigned         MAX_RETRY      = 2,
  parameter int unsigned         SETTLE_CYCLES  = 16,
  parameter int unsigned         HOLD_CYCLES    = 8,
  parameter int unsigned         FINAL_OWNER    = 1,
  localparam int SELW = ($clog2(N_STAGES) > 1) ? $clog2(N_STAGES) : 1,
  localparam int RW   = ($clog2(MAX_RETRY + 1) > 1) ? $clog2(MAX_RETRY + 1) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                restart_i,
  input  logic [N_STAGES-1:0] stage_done_i,
  output logic [N_STAGES-1:0] stage_rst_n_o,
  output logic [SELW-1:0]     bus_sel_o,
  output logic                busy_o,
  output logic                all_done_o,
  output logic                fail_o,
  output logic [SELW-1:0]     fail_stage_o,
  output logic [RW-1:0]       retry_cnt_o,
  output logic [N_STAGES-1:0] led_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_RELEASE, S_WAIT, S_HOLD, S_SETTLE, S_FINAL, S_DONE, S_FAIL
  } state_t;

  state_t              state_q, state_d;
  logic [SELW-1:0]     cur_q, cur_d;
  logic [31:0]         timer_q, timer_d;
  logic                first_q, first_d;
  logic [N_STAGES-1:0] rst_n_q, rst_n_d, led_q, led_d;
  logic [SELW-1:0]     bus_sel_q, bus_sel_d, fail_stage_q, fail_stage_d;
  logic                busy_q, busy_d, all_done_q, all_done_d, fail_q, fail_d;
  logic [RW-1:0]       retry_q, retry_d;

  logic            first_found, next_found, timeout;
  logic [SELW-1:0] first_idx, next_idx, undone_idx;

  // Lowest sequential stage, lowest sequential stage above cur_q, lowest undone stage.
  always_comb begin
    first_found = 1'b0;
    first_idx   = '0;
    next_found  = 1'b0;
    next_idx    = '0;
    undone_idx  = '0;
    for (int i = int'(N_STAGES) - 1; i >= 0; i--) begin
      if (!PARALLEL_MASK[i]) begin
        first_found = 1'b1;
        first_idx   = SELW'(i);
        if (i > int'(cur_q)) begin
          next_found = 1'b1;
          next_idx   = SELW'(i);
        end
      end
      if (!stage_done_i[i]) undone_idx = SELW'(i);
    end
  end

  assign timeout = (TIMEOUT_CYCLES != 0) && (timer_q == TIMEOUT_CYCLES - 1);

  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    timer_d      = timer_q;
    first_d      = first_q;
    rst_n_d      = rst_n_q;
    led_d        = led_q;
    bus_sel_d    = bus_sel_q;
    fail_stage_d = fail_stage_q;
    busy_d       = busy_q;
    all_done_d   = all_done_q;
    fail_d       = fail_q;
    retry_d      = retry_q;
    case (state_q)
      S_IDLE: begin
        busy_d  = 1'b1;
        rst_n_d = rst_n_q | PARALLEL_MASK;
        if (first_found) begin
          state_d = S_RELEASE;
          cur_d   = first_idx;
          first_d = 1'b1;
        end else begin
          state_d   = S_FINAL;
          bus_sel_d = SELW'(FINAL_OWNER);
          timer_d   = '0;
        end
      end
      S_RELEASE: begin
        rst_n_d[cur_q] = 1'b1;
        bus_sel_d      = cur_q;
        timer_d        = '0;
        if (first_q) retry_d = '0;
        first_d = 1'b0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (stage_done_i[cur_q]) begin
          led_d[cur_q] = 1'b0;
          timer_d      = '0;
          if (SETTLE_CYCLES != 0) state_d = S_SETTLE;
          else if (next_found) begin
            state_d = S_RELEASE;
            cur_d   = next_idx;
            first_d = 1'b1;
          end else begin
            state_d   = S_FINAL;
            bus_sel_d = SELW'(FINAL_OWNER);
          end
        end else if (timeout) begin
          rst_n_d[cur_q] = 1'b0;
          timer_d        = '0;
          if (retry_q == RW'(MAX_RETRY)) begin
            state_d      = S_FAIL;
            fail_d       = 1'b1;
            busy_d       = 1'b0;
            fail_stage_d = cur_q;
          end else begin
            retry_d = retry_q + RW'(1);
            // The RELEASE cycle counts toward the hold, so HOLD lasts one cycle less.
            state_d = (HOLD_CYCLES <= 1) ? S_RELEASE : S_HOLD;
          end
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      S_HOLD: begin
        if (timer_q == HOLD_CYCLES - 2) state_d = S_RELEASE;
        else timer_d = timer_q + 32'd1;
      end
      S_SETTLE: begin
        if (timer_q == SETTLE_CYCLES - 1) begin
          timer_d = '0;
          if (next_found) begin
            state_d = S_RELEASE;
            cur_d   = next_idx;
            first_d = 1'b1;
          end else begin
            state_d   = S_FINAL;
            bus_sel_d = SELW'(FINAL_OWNER);
          end
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      S_FINAL: begin
        if (&stage_done_i) begin
          led_d      = '0;
          state_d    = S_DONE;
          all_done_d = 1'b1;
          busy_d     = 1'b0;
        end else if (timeout) begin
          state_d      = S_FAIL;
          fail_d       = 1'b1;
          busy_d       = 1'b0;
          fail_stage_d = undone_idx;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      S_DONE, S_FAIL: begin
        if (restart_i) begin
          state_d      = S_IDLE;
          cur_d        = '0;
          timer_d      = '0;
          first_d      = 1'b0;
          rst_n_d      = '0;
          led_d        = '1;
          bus_sel_d    = '0;
          fail_stage_d = '0;
          busy_d       = 1'b0;
          all_done_d   = 1'b0;
          fail_d       = 1'b0;
          retry_d      = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cur_q        <= '0;
      timer_q      <= '0;
      first_q      <= 1'b0;
      rst_n_q      <= '0;
      led_q        <= '1;
      bus_sel_q    <= '0;
      fail_stage_q <= '0;
      busy_q       <= 1'b0;
      all_done_q   <= 1'b0;
      fail_q       <= 1'b0;
      retry_q      <= '0;
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      timer_q      <= timer_d;
      first_q      <= first_d;
      rst_n_q      <= rst_n_d;
      led_q        <= led_d;
      bus_sel_q    <= bus_sel_d;
      fail_stage_q <= fail_stage_d;
      busy_q       <= busy_d;
      all_done_q   <= all_done_d;
      fail_q       <= fail_d;
      retry_q      <= retry_d;
    end
  end

  assign stage_rst_n_o = rst_n_q;
  assign bus_sel_o     = bus_sel_q;
  assign busy_o        = busy_q;
  assign all_done_o    = all_done_q;
  assign fail_o        = fail_q;
  assign fail_stage_o  = fail_stage_q;
  assign retry_cnt_o   = retry_q;
  assign led_o         = led_q;

endmodule
